// File: rtl/spmmio_arbiter.sv
// spmmio_arbiter: two-master round-robin arbiter for the service-processor
// MMIO bus. Master 0 is the service CPU and master 1 is the debug/DMA engine.
// Both share one Wishbone-style slave port. Ownership lasts for a whole bus
// cycle (cyc). A watchdog ends strobes that the slave never acknowledges and
// reports them to the owner as an error.
//
// state | meaning
// IDLE  | no owner; all outputs 0; arbitrate between the cyc requests
// OWN0  | master 0 owns the slave port until m0_cyc_i drops
// OWN1  | master 1 owns the slave port until m1_cyc_i drops
module spmmio_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [23:0] m0_adr_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,

    input  logic [23:0] m1_adr_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,

    output logic [23:0] s_adr_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  owner_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Expiry fires when the count reaches TIMEOUT-1, which gives exactly
    // TIMEOUT strobe cycles before the error.
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] wdog_q, wdog_d;

    logic        own_cyc;
    logic        own_stb;
    logic        other_cyc;
    logic        expire;

    // Select the current owner's request lines. The watchdog expires only on
    // an active strobe that the slave is not acknowledging this cycle.
    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        other_cyc = 1'b0;
        case (state_q)
            OWN0: begin
                own_cyc   = m0_cyc_i;
                own_stb   = m0_stb_i;
                other_cyc = m1_cyc_i;
            end
            OWN1: begin
                own_cyc   = m1_cyc_i;
                own_stb   = m1_stb_i;
                other_cyc = m0_cyc_i;
            end
            default: begin
                own_cyc   = 1'b0;
                own_stb   = 1'b0;
                other_cyc = 1'b0;
            end
        endcase
        expire = own_cyc && own_stb && !s_ack_i && (wdog_q == WDOG_LAST);
    end

    // State, priority bit and watchdog registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next state: round-robin grant from IDLE, handover when the owner drops
    // cyc, and the watchdog count.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                wdog_d = 16'd0;
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    // The releasing master becomes the lowest priority. A
                    // waiting master takes over directly, without an IDLE gap.
                    last_d = (state_q == OWN1);
                    wdog_d = 16'd0;
                    if (other_cyc) begin
                        state_d = (state_q == OWN0) ? OWN1 : OWN0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!own_stb || s_ack_i || expire) begin
                    wdog_d = 16'd0;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wdog_d  = 16'd0;
            end
        endcase
    end

    // Outputs: route the owner to the slave and the slave back to the owner.
    // On expiry the strobe is pulled from the slave and the owner gets err.
    always_comb begin
        s_adr_o   = 24'd0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        s_sel_o   = 4'd0;
        s_we_o    = 1'b0;
        s_dat_o   = 32'd0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_dat_o  = 32'd0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_dat_o  = 32'd0;
        owner_o   = 2'b00;
        timeout_o = 1'b0;
        case (state_q)
            OWN0: begin
                s_adr_o   = m0_adr_i;
                s_stb_o   = m0_stb_i && !expire;
                s_cyc_o   = m0_cyc_i;
                s_sel_o   = m0_sel_i;
                s_we_o    = m0_we_i;
                s_dat_o   = m0_dat_i;
                m0_ack_o  = s_ack_i;
                m0_err_o  = expire;
                m0_dat_o  = s_ack_i ? s_dat_i : 32'd0;
                owner_o   = 2'b01;
                timeout_o = expire;
            end
            OWN1: begin
                s_adr_o   = m1_adr_i;
                s_stb_o   = m1_stb_i && !expire;
                s_cyc_o   = m1_cyc_i;
                s_sel_o   = m1_sel_i;
                s_we_o    = m1_we_i;
                s_dat_o   = m1_dat_i;
                m1_ack_o  = s_ack_i;
                m1_err_o  = expire;
                m1_dat_o  = s_ack_i ? s_dat_i : 32'd0;
                owner_o   = 2'b10;
                timeout_o = expire;
            end
            default: begin
                owner_o   = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_spmmio_arbiter.sv
// Directed, table-driven bench for spmmio_arbiter (TIMEOUT = 4).
module tb_spmmio_arbiter;

    localparam logic [23:0] M0_ADR = 24'h000010;
    localparam logic [23:0] M1_ADR = 24'h000020;
    localparam logic [31:0] M0_WD  = 32'hDEAD0000;
    localparam logic [31:0] M1_WD  = 32'h0000BEEF;
    localparam logic [3:0]  M0_SEL = 4'hF;
    localparam logic [3:0]  M1_SEL = 4'h3;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] m0_adr, m1_adr;
    logic        m0_stb, m0_cyc, m0_we, m1_stb, m1_cyc, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_wd, m1_wd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic [23:0] s_adr;
    logic        s_stb, s_cyc, s_we, s_ack;
    logic [3:0]  s_sel;
    logic [31:0] s_wd, s_rd;
    logic [1:0]  owner;
    logic        tmo;

    int n_cmp = 0;
    int n_err = 0;

    spmmio_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_dat_i(m0_wd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m0_dat_o(m0_rd),
        .m1_adr_i(m1_adr), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_dat_i(m1_wd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m1_dat_o(m1_rd),
        .s_adr_o(s_adr), .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_sel_o(s_sel),
        .s_we_o(s_we), .s_dat_o(s_wd), .s_ack_i(s_ack), .s_dat_i(s_rd),
        .owner_o(owner), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, c0, s0, c1, s1, ack;
        logic [31:0] sdat;
        logic [1:0]  own;
        logic        a0, a1, e0, e1, to, sstb, scyc;
        logic [31:0] d0, d1;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mk(logic rst, logic c0, logic s0, logic c1, logic s1,
                                logic ack, logic [31:0] sdat, logic [1:0] own,
                                logic a0, logic a1, logic e0, logic e1, logic to,
                                logic sstb, logic scyc, logic [31:0] d0, logic [31:0] d1);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
        v.sdat = sdat; v.own = own; v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
        v.to = to; v.sstb = sstb; v.scyc = scyc; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic c0, logic s0, logic c1, logic s1,
                         logic ack, logic [31:0] sdat);
        @(posedge clk);
        #1;
        reset  = rst;
        m0_cyc = c0; m0_stb = s0;
        m1_cyc = c1; m1_stb = s1;
        s_ack  = ack; s_rd = sdat;
    endtask

    // Compare every output against a vector; slave-side fields follow the owner.
    task automatic check_vec(string tag, vec_t v);
        logic [23:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
        logic        ew;
        ea = 24'd0; ed = 32'd0; es = 4'd0; ew = 1'b0;
        if (v.own == 2'b01) begin ea = M0_ADR; ed = M0_WD; es = M0_SEL; ew = 1'b1; end
        if (v.own == 2'b10) begin ea = M1_ADR; ed = M1_WD; es = M1_SEL; ew = 1'b0; end
        @(negedge clk);
        chk({tag, " owner"},   32'(owner),  32'(v.own));
        chk({tag, " m0_ack"},  32'(m0_ack), 32'(v.a0));
        chk({tag, " m1_ack"},  32'(m1_ack), 32'(v.a1));
        chk({tag, " m0_err"},  32'(m0_err), 32'(v.e0));
        chk({tag, " m1_err"},  32'(m1_err), 32'(v.e1));
        chk({tag, " timeout"}, 32'(tmo),    32'(v.to));
        chk({tag, " s_stb"},   32'(s_stb),  32'(v.sstb));
        chk({tag, " s_cyc"},   32'(s_cyc),  32'(v.scyc));
        chk({tag, " m0_dat"},  m0_rd,       v.d0);
        chk({tag, " m1_dat"},  m1_rd,       v.d1);
        chk({tag, " s_adr"},   32'(s_adr),  32'(ea));
        chk({tag, " s_dat"},   s_wd,        ed);
        chk({tag, " s_sel"},   32'(s_sel),  32'(es));
        chk({tag, " s_we"},    32'(s_we),   32'(ew));
    endtask

    initial begin
        reset = 1'b1;
        m0_adr = M0_ADR; m0_wd = M0_WD; m0_sel = M0_SEL; m0_we = 1'b1;
        m1_adr = M1_ADR; m1_wd = M1_WD; m1_sel = M1_SEL; m1_we = 1'b0;
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_rd = 0;

        //               rst c0 s0 c1 s1 ack sdat           own   a0 a1 e0 e1 to stb cyc d0            d1
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 1, 32'h12345678, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 1, 1, 0, 0, 1, 32'h12345678, 2'b01, 1, 0, 0, 0, 0, 1, 1, 32'h12345678, 32'h0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        2'b01, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[5]  = mk(0, 1, 1, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[6]  = mk(0, 1, 1, 1, 1, 1, 32'hAAAA5555, 2'b01, 1, 0, 0, 0, 0, 1, 1, 32'hAAAA5555, 32'h0);
        vecs[7]  = mk(0, 0, 0, 1, 1, 0, 32'h0,        2'b01, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[8]  = mk(0, 0, 0, 1, 1, 1, 32'h0BADF00D, 2'b10, 0, 1, 0, 0, 0, 1, 1, 32'h0,        32'h0BADF00D);
        vecs[9]  = mk(0, 1, 1, 0, 0, 0, 32'h0,        2'b10, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[10] = mk(0, 1, 1, 0, 0, 1, 32'hCAFEBABE, 2'b01, 1, 0, 0, 0, 0, 1, 1, 32'hCAFEBABE, 32'h0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 32'h0,        2'b01, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[12] = mk(0, 0, 0, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[13] = mk(0, 0, 0, 1, 1, 0, 32'h0,        2'b10, 0, 0, 0, 0, 0, 1, 1, 32'h0,        32'h0);
        vecs[14] = vecs[13];
        vecs[15] = vecs[13];
        vecs[16] = mk(0, 0, 0, 1, 1, 0, 32'h0,        2'b10, 0, 0, 0, 1, 1, 0, 1, 32'h0,        32'h0);
        vecs[17] = vecs[13];
        vecs[18] = vecs[13];
        vecs[19] = vecs[13];
        vecs[20] = mk(0, 0, 0, 1, 1, 1, 32'h11112222, 2'b10, 0, 1, 0, 0, 0, 1, 1, 32'h0,        32'h11112222);
        vecs[21] = vecs[13];
        vecs[22] = mk(1, 0, 0, 1, 1, 0, 32'h0,        2'b10, 0, 0, 0, 0, 0, 1, 1, 32'h0,        32'h0);
        vecs[23] = mk(0, 1, 1, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
        vecs[24] = mk(0, 1, 1, 1, 1, 1, 32'h13572468, 2'b01, 1, 0, 0, 0, 0, 1, 1, 32'h13572468, 32'h0);

        drive(1, 0, 0, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1,
                  vecs[i].ack, vecs[i].sdat);
            check_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Fairness: both masters keep requesting; each owner releases after one
        // acked transfer, so grants must alternate m0, m1, ... with no gap.
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        drive(0, 1, 1, 1, 1, 0, 32'h0);
        @(negedge clk);
        chk("fair start owner", 32'(owner), 32'd0);
        for (int i = 0; i < 8; i++) begin
            logic [1:0] exp_own;
            exp_own = (i % 2 == 0) ? 2'b01 : 2'b10;
            drive(0, 1, 1, 1, 1, 1, 32'(i + 100));
            @(negedge clk);
            chk($sformatf("fair%0d owner", i), 32'(owner), 32'(exp_own));
            chk($sformatf("fair%0d ack", i),
                32'(exp_own == 2'b01 ? m0_ack : m1_ack), 32'd1);
            chk($sformatf("fair%0d dat", i),
                exp_own == 2'b01 ? m0_rd : m1_rd, 32'(i + 100));
            if (exp_own == 2'b01) drive(0, 0, 0, 1, 1, 0, 32'h0);
            else                  drive(0, 1, 1, 0, 0, 0, 32'h0);
            @(negedge clk);
            chk($sformatf("fair%0d release owner", i), 32'(owner), 32'(exp_own));
            chk($sformatf("fair%0d release cyc", i), 32'(s_cyc), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spmmio_arbiter.md
Name: spmmio_arbiter

Overview:
- Two-master arbiter for the service-processor MMIO bus.
- Shares one Wishbone-style slave port, which feeds the MMIO decoder, between master 0 (service CPU) and master 1 (debug/DMA engine).
- Arbitration is round-robin. Ownership is held for the whole bus cycle (cyc). A watchdog terminates accesses the slave never acknowledges, with an error.

Parameters:
- TIMEOUT, 64: cycles an owner strobe may wait for s_ack_i before error termination. Legal range 2..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_adr_i / m1_adr_i  in  [0:23]  master address; bit 21 is the LSB used
- m0_stb_i / m1_stb_i  in  1  master strobe
- m0_cyc_i / m1_cyc_i  in  1  master bus cycle; also the bus request
- m0_sel_i / m1_sel_i  in  [0:3]  byte selects
- m0_we_i / m1_we_i  in  1  write enable
- m0_dat_i / m1_dat_i  in  [0:31]  write data
- m0_ack_o / m1_ack_o  out  1  transfer acknowledge
- m0_err_o / m1_err_o  out  1  timeout error termination
- m0_dat_o / m1_dat_o  out  [0:31]  read data
- s_adr_o  out  [0:23]  slave address
- s_stb_o  out  1  slave strobe
- s_cyc_o  out  1  slave cycle
- s_sel_o  out  [0:3]  slave byte selects
- s_we_o  out  1  slave write enable
- s_dat_o  out  [0:31]  slave write data
- s_ack_i  in  1  slave acknowledge; may be combinational from s_stb_o
- s_dat_i  in  [0:31]  slave read data
- owner_o  out  [0:1]  one-hot current owner: bit0 = m0, bit1 = m1
- timeout_o  out  1  one-cycle pulse on any timeout

Behaviour:
- State register: IDLE, OWN0, OWN1.
- Priority bit `last` records the most recent owner.
- On reset: state = IDLE, last = 1 (m0 wins the first tie), watchdog count = 0, timeout_o = 0.
- In IDLE, all outputs are 0.
- IDLE transitions, evaluated each cycle:
  - Only mN_cyc_i high -> OWNN.
  - Both high -> OWN of the master not equal to last.
  - Neither -> stay in IDLE.
- Grant is registered. A request first seen in cycle t reaches the slave in cycle t+1 at the earliest.
- OWNN outputs:
  - s_* = mN_* (all fields).
  - mN_ack_o = s_ack_i.
  - mN_dat_o = s_dat_i while s_ack_i is high, else 0.
  - The non-owner sees ack = 0, err = 0, dat = 0.
  - owner_o reflects the state.
- Outside OWN, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o are 0.
- Ownership is held while mN_cyc_i = 1. Strobes may come and go inside the cycle; the other master waits.
- Owner drops cyc:
  - last <= N.
  - Other master's cyc high -> OWN(other) directly; no dead cycle.
  - Otherwise -> IDLE.
  - If the owner re-raises cyc in that same cycle, it is treated as idle and competes again next cycle.
- Watchdog count, 16 bits:
  - Increments each cycle the owner has stb&cyc high and s_ack_i low.
  - Cleared on s_ack_i, on the owner's stb low, on an ownership change, and on reset.
- Watchdog expiry, when count == TIMEOUT-1 and ack is still low:
  - In that cycle: mN_err_o = 1 and timeout_o = 1.
  - s_stb_o is forced to 0 that cycle; mN_ack_o stays 0 and mN_dat_o = 0.
  - Count clears. The master keeps ownership until it drops cyc.
- s_ack_i and expiry in the same cycle: ack wins; no err, no timeout_o.
- s_ack_i while IDLE: ignored; no master sees it.
- Reset asserted mid-transfer: the cycle after the reset sample is IDLE with all outputs 0. In-flight access is abandoned, no ack or err is generated, and `last` returns to 1.
- Latency: the arbiter adds 0 cycles to the data phase after grant, and 1 grant cycle from IDLE.

Test Plan:
- Single read: m0 cyc/stb with adr 0x000010 from cycle 1; slave acks combinationally with 0x12345678 -> owner_o = 01 in cycle 2; m0_ack_o = 1 and m0_dat_o = 0x12345678 in cycle 2; m1 outputs stay 0.
- Simultaneous request after reset: m0 and m1 cyc high in the same cycle -> m0 granted first. Keep both requesting, m0 drops cyc after one ack -> next cycle owner_o = 10 with no IDLE gap. m1 drops cyc and m0 re-requests -> m0 granted.
- Fairness: both masters continuously re-request, each releasing after one transfer -> grants strictly alternate m0, m1, m0, m1 over 8 transfers.
- Timeout, TIMEOUT = 4: m1 owns with stb high and s_ack_i stuck low -> m1_err_o and timeout_o high exactly in the 4th strobe cycle. s_stb_o is low that cycle and m1_ack_o stays 0. Count restarts from 0 while the strobe continues.
- Ack at expiry edge, TIMEOUT = 4: s_ack_i rises in the 4th strobe cycle -> m1_ack_o = 1, no err, no timeout_o.
- Reset mid-transfer: assert reset while m1 owns with stb pending -> next cycle owner_o = 00 and all s_* are 0. After release with both requesting, m0 is granted.
